serial_sub: RTL and testbench

- Bit-serial N-bit unsigned subtractor, the multi-bit stage built directly on the 1-bit subtract cell (a_in, b_in -> d_out, borrow).
- Loads two operands on a start pulse, then processes one bit per clock, LSB first, through a 1-bit difference/borrow datapath with a registered borrow chain.
- Returns the full-width difference and the final borrow with a done pulse.
- Sits between operand producers and any consumer that needs A-B with an area-minimal datapath.

---
 rtl/serial_sub.sv | 117 +++++++++++
 tb/tb_serial_sub.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// through a single subtract cell with a registered borrow chain.
module serial_sub #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out,
    output logic             borrow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sr_reg, b_sr_reg, res_sr_reg;
    logic [WIDTH-1:0]   res_sr_next;
    logic [WIDTH-1:0]   d_out_reg;
    logic               borrow_out_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               diff_bit, borrow_bit, last_bit;

    // One-bit subtract cell fed from the operand LSBs and the borrow flop.
    always_comb begin
        diff_bit    = a_sr_reg[0] ^ b_sr_reg[0] ^ c_reg;
        borrow_bit  = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & c_reg);
        res_sr_next = {diff_bit, res_sr_reg[WIDTH-1:1]};
        last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_reg       <= '0;
            b_sr_reg       <= '0;
            res_sr_reg     <= '0;
            c_reg          <= 1'b0;
            cnt_reg        <= '0;
            d_out_reg      <= '0;
            borrow_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr_reg   <= a_in;
                        b_sr_reg   <= b_in;
                        res_sr_reg <= '0;
                        c_reg      <= 1'b0;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    res_sr_reg <= res_sr_next;
                    c_reg      <= borrow_bit;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Outputs only change when the final bit lands, so the
                    // partial result never shows on d_out.
                    if (last_bit) begin
                        d_out_reg      <= res_sr_next;
                        borrow_out_reg <= borrow_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign d_out  = d_out_reg;
    assign borrow = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever done is presented.
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, done, borrow;
    logic [WIDTH-1:0] d_out;

    int errors = 0;
    int checks = 0;

    logic [WIDTH:0] exp_q[$];
    int             cyc = 0;
    int             last_done_cyc = -1;
    logic           spacing_chk = 1'b0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .d_out  (d_out),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done is compared against the oldest expected result.
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: d_out=0x%0h borrow=%0d with empty scoreboard", d_out, borrow);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("d_out", int'(d_out), int'(e[WIDTH-1:0]));
                check("borrow", int'(borrow), int'(e[WIDTH]));
            end
            if (spacing_chk && last_done_cyc >= 0)
                check("done_spacing", cyc - last_done_cyc, WIDTH + 2);
            last_done_cyc = cyc;
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("idle_timeout", 1, 0);
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    // Issue one operation from a negedge; returns one negedge after the start edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit expect_result);
        wait_idle();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        if (expect_result) exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, busy_n;

        // 1: reset and idle quiet period
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d_out", int'(d_out), 0);
        check("rst_borrow", int'(borrow), 0);
        repeat (20) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_d_out", int'(d_out), 0);

        // 2: latency and hold
        issue(8'h5A, 8'h3C, 1'b1);
        n = 1;
        busy_n = int'(busy);
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        check("done_latency", n, WIDTH + 1);
        check("busy_cycles", busy_n, WIDTH);
        @(negedge clk);
        check("done_falls", int'(done), 0);
        repeat (3) @(negedge clk);
        check("hold_d_out", int'(d_out), 8'h1E);
        check("hold_borrow", int'(borrow), 0);

        // 3: boundary operands
        issue(8'h00, 8'h01, 1'b1);
        issue(8'hFF, 8'hFF, 1'b1);
        issue(8'h80, 8'h7F, 1'b1);
        drain();

        // 4: start during SHIFT is ignored
        issue(8'h10, 8'h20, 1'b1);
        repeat (2) @(negedge clk);
        a_in  = 8'hAA;
        b_in  = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (WIDTH + 4) @(negedge clk);

        // 5: asynchronous reset mid-operation
        issue(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_d_out", int'(d_out), 0);
        check("arst_borrow", int'(borrow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 4) @(negedge clk);
        issue(8'h09, 8'h03, 1'b1);
        drain();

        // 6: start tied high, random operands, fixed throughput
        last_done_cyc = -1;
        spacing_chk   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] ra, rb;
            wait_idle();
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            a_in = ra;
            b_in = rb;
            exp_q.push_back(model(ra, rb));
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        spacing_chk = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
